// File: rtl/sync_fifo_v2_if.sv
// Handshake and status bundle for sync_fifo_v2: the producer/consumer side
// drives the master modport, the FIFO implements the slave modport.
interface sync_fifo_v2_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CntW-1:0]  count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_v2.sv
// Parametrised single-clock FIFO with programmable almost-full/empty thresholds,
// sticky overflow/underflow flags and a choice of registered-read or FWFT output.
module sync_fifo_v2 #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_v2_if.slave  fifo_io
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic full, empty;
  logic wa, ra;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign wa    = fifo_io.wr_en & ~full;
  assign ra    = fifo_io.rd_en & ~empty;

  // Explicit wrap so non-power-of-two depths never index past the array.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wa) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (ra) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({wa, ra})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new offence in the same cycle as clr_err keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (fifo_io.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (fifo_io.wr_en && full) begin
      ovf_d = 1'b1;
    end
    if (fifo_io.rd_en && empty) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wa) begin
      mem_q[wr_ptr_q] <= fifo_io.din;
    end
  end

  assign fifo_io.full         = full;
  assign fifo_io.empty        = empty;
  assign fifo_io.almost_full  = (count_q >= CntW'(AF_LEVEL));
  assign fifo_io.almost_empty = (count_q <= CntW'(AE_LEVEL));
  assign fifo_io.count        = count_q;
  assign fifo_io.overflow     = ovf_q;
  assign fifo_io.underflow    = udf_q;

  if (FWFT) begin : g_fwft
    assign fifo_io.dout       = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_io.dout_valid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_valid_q <= ra;
        if (ra) begin
          dout_q <= mem_q[rd_ptr_q];
        end
      end
    end

    assign fifo_io.dout       = dout_q;
    assign fifo_io.dout_valid = dout_valid_q;
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= CntW'(DEPTH));
  a_wr_ptr_range: assert property (@(posedge clk) disable iff (rst) 32'(wr_ptr_q) < DEPTH);
  a_rd_ptr_range: assert property (@(posedge clk) disable iff (rst) 32'(rd_ptr_q) < DEPTH);

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Randomised and directed bench for sync_fifo_v2: three configurations are exercised
// one after another against a queue-based reference model.
module tb_sync_fifo_v2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_v2_if #(.WIDTH(8), .DEPTH(16)) if_std ();
  sync_fifo_v2_if #(.WIDTH(8), .DEPTH(12)) if_wrap ();
  sync_fifo_v2_if #(.WIDTH(8), .DEPTH(16)) if_fwft ();

  sync_fifo_v2 #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)
  ) u_std (
    .clk(clk), .rst(rst), .fifo_io(if_std)
  );

  sync_fifo_v2 #(
    .WIDTH(8), .DEPTH(12), .AF_LEVEL(10), .AE_LEVEL(2), .FWFT(1'b0)
  ) u_wrap (
    .clk(clk), .rst(rst), .fifo_io(if_wrap)
  );

  sync_fifo_v2 #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)
  ) u_fwft (
    .clk(clk), .rst(rst), .fifo_io(if_fwft)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  int          sel      = 0;
  int unsigned cur_depth = 16;
  int unsigned cur_af    = 14;
  int unsigned cur_ae    = 2;
  bit          cur_fwft  = 1'b0;
  bit          chk_en    = 1'b0;

  // Reference model: contents as a queue plus the observable sticky/output state.
  logic [7:0] mq [$];
  bit         m_ovf, m_udf, m_dv;
  logic [7:0] m_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s (cfg %0d, t=%0t): got 0x%0h, expected 0x%0h", tag, sel, $time, obs, exp);
  endtask

  task automatic check_all();
    logic [7:0]  d;
    logic        dv, fl, em, af, ae, ov, ud;
    logic [31:0] cnt;
    int unsigned n;
    case (sel)
      0: begin
        d = if_std.dout; dv = if_std.dout_valid; fl = if_std.full; em = if_std.empty;
        af = if_std.almost_full; ae = if_std.almost_empty; ov = if_std.overflow;
        ud = if_std.underflow; cnt = 32'(if_std.count);
      end
      1: begin
        d = if_wrap.dout; dv = if_wrap.dout_valid; fl = if_wrap.full; em = if_wrap.empty;
        af = if_wrap.almost_full; ae = if_wrap.almost_empty; ov = if_wrap.overflow;
        ud = if_wrap.underflow; cnt = 32'(if_wrap.count);
      end
      default: begin
        d = if_fwft.dout; dv = if_fwft.dout_valid; fl = if_fwft.full; em = if_fwft.empty;
        af = if_fwft.almost_full; ae = if_fwft.almost_empty; ov = if_fwft.overflow;
        ud = if_fwft.underflow; cnt = 32'(if_fwft.count);
      end
    endcase
    n = mq.size();
    check("count", cnt, n);
    check("full", 32'(fl), 32'(n == cur_depth));
    check("empty", 32'(em), 32'(n == 0));
    check("almost_full", 32'(af), 32'(n >= cur_af));
    check("almost_empty", 32'(ae), 32'(n <= cur_ae));
    check("overflow", 32'(ov), 32'(m_ovf));
    check("underflow", 32'(ud), 32'(m_udf));
    if (cur_fwft) begin
      check("dout_valid", 32'(dv), 32'(n != 0));
      check("dout", 32'(d), (n == 0) ? 32'h0 : 32'(mq[0]));
    end else begin
      check("dout_valid", 32'(dv), 32'(m_dv));
      check("dout", 32'(d), 32'(m_dout));
    end
  endtask

  task automatic drive(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    if_std.wr_en   = wr && (sel == 0);
    if_std.rd_en   = rd && (sel == 0);
    if_std.clr_err = clr && (sel == 0);
    if_std.din     = d;
    if_wrap.wr_en   = wr && (sel == 1);
    if_wrap.rd_en   = rd && (sel == 1);
    if_wrap.clr_err = clr && (sel == 1);
    if_wrap.din     = d;
    if_fwft.wr_en   = wr && (sel == 2);
    if_fwft.rd_en   = rd && (sel == 2);
    if_fwft.clr_err = clr && (sel == 2);
    if_fwft.din     = d;
  endtask

  // Check the state left by the previous edge, then apply inputs for the next edge.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit clr,
                      input bit rs);
    int unsigned n;
    bit is_full, is_empty, wa, ra;
    @(negedge clk);
    if (chk_en) check_all();
    drive(wr, d, rd, clr);
    rst = rs;
    n = mq.size();
    is_full  = (n == cur_depth);
    is_empty = (n == 0);
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0; m_dout = 8'h00;
    end else begin
      wa = wr && !is_full;
      ra = rd && !is_empty;
      if (!cur_fwft) begin
        m_dv = ra;
        if (ra) m_dout = mq[0];
      end
      if (ra) void'(mq.pop_front());
      if (wa) mq.push_back(d);
      if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (wr && is_full) m_ovf = 1'b1;
      if (rd && is_empty) m_udf = 1'b1;
    end
  endtask

  task automatic start_phase(input int s, input int unsigned dep, input int unsigned af,
                             input int unsigned ae, input bit fw);
    if (chk_en) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    sel = s; cur_depth = dep; cur_af = af; cur_ae = ae; cur_fwft = fw;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
  endtask

  task automatic rand_run(input int cycles);
    int unsigned pw = 50, pr = 50;
    for (int c = 0; c < cycles; c++) begin
      if (c % 32 == 0) begin
        pw = 10 + 40 * $urandom_range(2);
        pr = 10 + 40 * $urandom_range(2);
      end
      step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
           $urandom_range(99) < 4, $urandom_range(999) < 3);
    end
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    // Standard mode, DEPTH=16.
    start_phase(0, 16, 14, 2, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    rand_run(500);

    // Non-power-of-two depth with sustained traffic across the wrap point.
    start_phase(1, 12, 10, 2, 1'b0);
    begin
      int written = 0;
      for (int c = 0; c < 400; c++) begin
        bit wr, rd;
        if (written == 40 && mq.size() == 0) break;
        wr = (written < 40) && (mq.size() < 10) && ($urandom_range(3) != 0);
        rd = (mq.size() > 0) && (mq.size() > 3 || written == 40) && ($urandom_range(3) != 0);
        step(wr, 8'(written), rd, 1'b0, 1'b0);
        if (wr) written++;
      end
      check("wrap_stream_done", 32'(written), 32'd40);
    end
    rand_run(400);

    // First-word-fall-through, DEPTH=16.
    start_phase(2, 16, 14, 2, 1'b1);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rand_run(500);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
